// File: rtl/cmp_stream_nlane_if.sv
// Stream interface for cmp_stream_nlane: input transaction channel and registered result channel.
interface cmp_stream_nlane_if #(
  parameter int WIDTH = 8,
  parameter int LANES = 4
);
  logic                   in_valid;
  logic                   in_ready;
  logic [LANES*WIDTH-1:0] in_a;
  logic [LANES*WIDTH-1:0] in_b;
  logic [1:0]             in_op;
  logic [LANES-1:0]       in_lane_en;
  logic                   out_valid;
  logic                   out_ready;
  logic [LANES-1:0]       out_eq;
  logic [LANES-1:0]       out_lt;
  logic [LANES-1:0]       out_match;
  logic                   out_all_match;

  modport master (
    output in_valid, in_a, in_b, in_op, in_lane_en, out_ready,
    input  in_ready, out_valid, out_eq, out_lt, out_match, out_all_match
  );

  modport slave (
    input  in_valid, in_a, in_b, in_op, in_lane_en, out_ready,
    output in_ready, out_valid, out_eq, out_lt, out_match, out_all_match
  );
endinterface

// File: rtl/cmp_stream_nlane.sv
// N-lane relational comparator with a one-deep registered result stage and a
// saturating counter of all-lane-match results.
module cmp_stream_nlane #(
  parameter int WIDTH  = 8,
  parameter int LANES  = 4,
  parameter int SIGNED = 0,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  cmp_stream_nlane_if.slave s,
  input  logic             cnt_clear,
  output logic [CNT_W-1:0] match_cnt
);
  // Handshake: a transfer happens on a rising edge where valid && ready are
  // both high. in_ready = !out_valid || out_ready, so the result register is
  // either empty or being drained whenever a new input is taken.

  logic [LANES-1:0] w_eq;
  logic [LANES-1:0] w_lt;
  logic [LANES-1:0] w_match;
  logic             w_all_match;
  logic             w_in_xfer;
  logic             w_out_xfer;

  logic             r_valid;
  logic [LANES-1:0] r_eq;
  logic [LANES-1:0] r_lt;
  logic [LANES-1:0] r_match;
  logic             r_all_match;
  logic [CNT_W-1:0] r_cnt;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic             w_eq_raw;
    logic             w_lt_raw;
    logic             w_match_raw;

    assign w_a      = s.in_a[g*WIDTH +: WIDTH];
    assign w_b      = s.in_b[g*WIDTH +: WIDTH];
    assign w_eq_raw = (w_a == w_b);

    if (SIGNED != 0) begin : g_signed
      assign w_lt_raw = ($signed(w_a) < $signed(w_b));
    end else begin : g_unsigned
      assign w_lt_raw = (w_a < w_b);
    end

    assign w_match_raw = (s.in_op == 2'd0) ?  w_eq_raw :
                         (s.in_op == 2'd1) ? !w_eq_raw :
                         (s.in_op == 2'd2) ?  w_lt_raw :
                                             !w_lt_raw;

    // Disabled lanes report 0 on every per-lane flag.
    assign w_eq[g]    = s.in_lane_en[g] & w_eq_raw;
    assign w_lt[g]    = s.in_lane_en[g] & w_lt_raw;
    assign w_match[g] = s.in_lane_en[g] & w_match_raw;
  end

  // Disabled lanes count as matching; an empty mask never matches.
  assign w_all_match = (|s.in_lane_en) & (&(w_match | ~s.in_lane_en));

  assign s.in_ready = !r_valid || s.out_ready;
  assign w_in_xfer  = s.in_valid && s.in_ready;
  assign w_out_xfer = r_valid && s.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid     <= 1'b0;
      r_eq        <= '0;
      r_lt        <= '0;
      r_match     <= '0;
      r_all_match <= 1'b0;
    end else if (s.in_ready) begin
      r_valid <= s.in_valid;
      if (w_in_xfer) begin
        r_eq        <= w_eq;
        r_lt        <= w_lt;
        r_match     <= w_match;
        r_all_match <= w_all_match;
      end
    end
  end

  // Clear wins over a same-cycle increment; the count sticks at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (cnt_clear) begin
      r_cnt <= '0;
    end else if (w_out_xfer && r_all_match && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign s.out_valid     = r_valid;
  assign s.out_eq        = r_eq;
  assign s.out_lt        = r_lt;
  assign s.out_match     = r_match;
  assign s.out_all_match = r_all_match;
  assign match_cnt       = r_cnt;
endmodule

// File: tb/tb_cmp_stream_nlane.sv
// Bench for cmp_stream_nlane: an unsigned/16-bit-counter instance and a signed/2-bit-counter
// instance share one stimulus stream and are checked against a lane-by-lane arithmetic model.
module tb_cmp_stream_nlane;
  localparam int WIDTH = 8;
  localparam int LANES = 4;
  localparam int RW    = 3*LANES + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                   tb_in_valid  = 1'b0;
  logic [LANES*WIDTH-1:0] tb_a         = '0;
  logic [LANES*WIDTH-1:0] tb_b         = '0;
  logic [1:0]             tb_op        = 2'd0;
  logic [LANES-1:0]       tb_en        = '0;
  logic                   tb_out_ready = 1'b1;
  logic                   tb_cnt_clear = 1'b0;

  cmp_stream_nlane_if #(.WIDTH(WIDTH), .LANES(LANES)) bus0 ();
  cmp_stream_nlane_if #(.WIDTH(WIDTH), .LANES(LANES)) bus1 ();

  assign bus0.in_valid   = tb_in_valid;
  assign bus0.in_a       = tb_a;
  assign bus0.in_b       = tb_b;
  assign bus0.in_op      = tb_op;
  assign bus0.in_lane_en = tb_en;
  assign bus0.out_ready  = tb_out_ready;
  assign bus1.in_valid   = tb_in_valid;
  assign bus1.in_a       = tb_a;
  assign bus1.in_b       = tb_b;
  assign bus1.in_op      = tb_op;
  assign bus1.in_lane_en = tb_en;
  assign bus1.out_ready  = tb_out_ready;

  logic [15:0] cnt0_o;
  logic [1:0]  cnt1_o;

  cmp_stream_nlane #(.WIDTH(WIDTH), .LANES(LANES), .SIGNED(0), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst), .s(bus0), .cnt_clear(tb_cnt_clear), .match_cnt(cnt0_o)
  );
  cmp_stream_nlane #(.WIDTH(WIDTH), .LANES(LANES), .SIGNED(1), .CNT_W(2)) dut1 (
    .clk(clk), .rst(rst), .s(bus1), .cnt_clear(tb_cnt_clear), .match_cnt(cnt1_o)
  );

  // Scoreboard: results in flight per instance, plus expected counters.
  logic [RW-1:0] exp0_q[$];
  logic [RW-1:0] exp1_q[$];
  int unsigned   cnt0_m = 0;
  int unsigned   cnt1_m = 0;
  int            n_cmp  = 0;
  int            n_err  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected {eq, lt, match, all_match} from plain integer comparisons.
  function automatic logic [RW-1:0] ref_result(input logic [LANES*WIDTH-1:0] a,
      input logic [LANES*WIDTH-1:0] b, input logic [1:0] op,
      input logic [LANES-1:0] en, input bit sgn);
    logic [LANES-1:0] eq, lt, m;
    logic             all;
    int               av, bv;
    eq = '0; lt = '0; m = '0;
    for (int i = 0; i < LANES; i++) begin
      if (en[i]) begin
        av = int'(a[i*WIDTH +: WIDTH]);
        bv = int'(b[i*WIDTH +: WIDTH]);
        if (sgn && av >= (1 << (WIDTH-1))) av = av - (1 << WIDTH);
        if (sgn && bv >= (1 << (WIDTH-1))) bv = bv - (1 << WIDTH);
        eq[i] = (av == bv);
        lt[i] = (av < bv);
        case (op)
          2'd0:    m[i] = eq[i];
          2'd1:    m[i] = !eq[i];
          2'd2:    m[i] = lt[i];
          default: m[i] = !lt[i];
        endcase
      end
    end
    all = (en != '0) && ((m & en) == en);
    return {eq, lt, m, all};
  endfunction

  task automatic check_outputs();
    logic exp_ready;
    exp_ready = (exp0_q.size() == 0) || tb_out_ready;
    check("in_ready0", 64'(bus0.in_ready), 64'(exp_ready));
    check("in_ready1", 64'(bus1.in_ready), 64'(exp_ready));
    check("out_valid0", 64'(bus0.out_valid), 64'(exp0_q.size() != 0));
    check("out_valid1", 64'(bus1.out_valid), 64'(exp1_q.size() != 0));
    if (exp0_q.size() != 0)
      check("data0", 64'({bus0.out_eq, bus0.out_lt, bus0.out_match, bus0.out_all_match}), 64'(exp0_q[0]));
    if (exp1_q.size() != 0)
      check("data1", 64'({bus1.out_eq, bus1.out_lt, bus1.out_match, bus1.out_all_match}), 64'(exp1_q[0]));
    check("match_cnt0", 64'(cnt0_o), 64'(cnt0_m));
    check("match_cnt1", 64'(cnt1_o), 64'(cnt1_m));
  endtask

  // One clock: check at the falling edge, update the model at the rising edge.
  task automatic step();
    logic          tx_in, tx_out;
    logic [RW-1:0] r0, r1;
    @(negedge clk);
    check_outputs();
    tx_out = (exp0_q.size() != 0) && tb_out_ready;
    tx_in  = tb_in_valid && ((exp0_q.size() == 0) || tb_out_ready);
    @(posedge clk);
    if (tx_out) begin
      r0 = exp0_q.pop_front();
      r1 = exp1_q.pop_front();
      if (r0[0] && cnt0_m != 65535) cnt0_m++;
      if (r1[0] && cnt1_m != 3) cnt1_m++;
    end
    if (tb_cnt_clear) begin
      cnt0_m = 0;
      cnt1_m = 0;
    end
    if (tx_in) begin
      exp0_q.push_back(ref_result(tb_a, tb_b, tb_op, tb_en, 1'b0));
      exp1_q.push_back(ref_result(tb_a, tb_b, tb_op, tb_en, 1'b1));
    end
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
      input logic [1:0] op, input logic [3:0] en);
    tb_in_valid = v;
    tb_a        = a;
    tb_b        = b;
    tb_op       = op;
    tb_en       = en;
  endtask

  task automatic drive_random();
    logic [31:0] a, b;
    a = $urandom;
    b = $urandom;
    for (int i = 0; i < LANES; i++)
      if ($urandom_range(0, 1) == 1) b[i*WIDTH +: WIDTH] = a[i*WIDTH +: WIDTH];
    drive(1'($urandom_range(0, 3) != 0), a, b, 2'($urandom_range(0, 3)),
          ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 15)));
  endtask

  initial begin
    // Reset state, observed while reset is still asserted.
    #3;
    check("rst_out_valid", 64'(bus0.out_valid), 64'd0);
    check("rst_in_ready", 64'(bus0.in_ready), 64'd1);
    check("rst_data0", 64'({bus0.out_eq, bus0.out_lt, bus0.out_match, bus0.out_all_match}), 64'd0);
    check("rst_data1", 64'({bus1.out_eq, bus1.out_lt, bus1.out_match, bus1.out_all_match}), 64'd0);
    check("rst_cnt0", 64'(cnt0_o), 64'd0);
    check("rst_cnt1", 64'(cnt1_o), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // EQ, all lanes equal.
    drive(1'b1, 32'h01020304, 32'h01020304, 2'd0, 4'hF);
    step();
    check("eq_out_eq", 64'(bus0.out_eq), 64'hF);
    check("eq_out_match", 64'(bus0.out_match), 64'hF);
    check("eq_all_match", 64'(bus0.out_all_match), 64'd1);
    drive(1'b0, '0, '0, 2'd0, 4'h0);
    step();
    check("eq_cnt_after", 64'(cnt0_o), 64'd1);

    // 0x80 vs 0x01 on lane 0: ordering depends on signedness.
    drive(1'b1, 32'h00000080, 32'h00000001, 2'd2, 4'h1);
    step();
    check("lt_unsigned", 64'(bus0.out_lt[0]), 64'd0);
    check("lt_signed", 64'(bus1.out_lt[0]), 64'd1);
    drive(1'b1, 32'h00000080, 32'h00000001, 2'd3, 4'h1);
    step();
    check("ge_unsigned", 64'(bus0.out_match[0]), 64'd1);
    check("ge_signed", 64'(bus1.out_match[0]), 64'd0);

    // Masked lanes 1 and 3 mismatch but are disabled; then an empty mask.
    drive(1'b1, 32'h11223344, 32'h55227744, 2'd0, 4'b0101);
    step();
    check("mask_eq", 64'({bus0.out_eq[3], bus0.out_eq[1]}), 64'd0);
    check("mask_all", 64'(bus0.out_all_match), 64'd1);
    drive(1'b1, 32'h11223344, 32'h11223344, 2'd0, 4'h0);
    step();
    check("empty_mask_all", 64'(bus0.out_all_match), 64'd0);

    // Backpressure with in_valid held high, then release into a streaming burst.
    tb_out_ready = 1'b0;
    drive_random();
    tb_in_valid = 1'b1;
    repeat (5) step();
    check("bp_in_ready", 64'(bus0.in_ready), 64'd0);
    tb_out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive_random();
      tb_in_valid = 1'b1;
      step();
    end
    tb_in_valid = 1'b0;
    step();
    step();

    // Two-bit counter saturates; clear wins over a same-cycle all-match transfer.
    tb_cnt_clear = 1'b1;
    step();
    tb_cnt_clear = 1'b0;
    drive(1'b1, 32'hA5A5A5A5, 32'hA5A5A5A5, 2'd0, 4'hF);
    repeat (5) step();
    tb_in_valid = 1'b0;
    step();
    check("sat_cnt1", 64'(cnt1_o), 64'd3);
    check("sat_cnt0", 64'(cnt0_o), 64'd5);
    tb_in_valid = 1'b1;
    step();
    tb_in_valid  = 1'b0;
    tb_cnt_clear = 1'b1;
    step();
    tb_cnt_clear = 1'b0;
    check("clr_cnt1", 64'(cnt1_o), 64'd0);
    check("clr_cnt0", 64'(cnt0_o), 64'd0);

    // Random traffic with random backpressure and occasional clears.
    for (int i = 0; i < 300; i++) begin
      drive_random();
      tb_out_ready = 1'($urandom_range(0, 2) != 0);
      tb_cnt_clear = 1'($urandom_range(0, 19) == 0);
      step();
    end
    tb_cnt_clear = 1'b0;

    // Reset while a result is held and a new input is offered.
    tb_out_ready = 1'b0;
    drive(1'b1, 32'h01020304, 32'h01020304, 2'd0, 4'hF);
    step();
    rst = 1'b1;
    #2;
    check("mid_rst_out_valid", 64'(bus0.out_valid), 64'd0);
    check("mid_rst_in_ready", 64'(bus0.in_ready), 64'd1);
    check("mid_rst_cnt0", 64'(cnt0_o), 64'd0);
    check("mid_rst_cnt1", 64'(cnt1_o), 64'd0);
    exp0_q.delete();
    exp1_q.delete();
    cnt0_m = 0;
    cnt1_m = 0;
    tb_in_valid  = 1'b0;
    tb_out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/cmp_stream_nlane.md
Name: cmp_stream_nlane

Overview:
Parametrised, pipelined successor to the 3-bit equality comparator. Compares LANES independent WIDTH-bit operand pairs per transaction and supports signed or unsigned magnitude ordering. Each lane takes a per-transaction relational op and an enable mask. Results are registered behind a valid/ready stream handshake. A saturating counter of all-lane-match transactions is provided for datapath checking logic.

Parameters:
WIDTH, 8, bits per lane operand (>=1)
LANES, 4, number of parallel compare lanes (>=1)
SIGNED, 0, 1 = two's-complement ordering for lt, 0 = unsigned ordering
CNT_W, 16, width of the match counter (>=1)

Ports:
clk  input  1  single clock, rising edge
rst  input  1  reset, asynchronous, active-high
in_valid  input  1  input transaction valid
in_ready  output  1  block can accept an input transaction
in_a  input  LANES*WIDTH  operand A; lane i = in_a[i*WIDTH +: WIDTH]
in_b  input  LANES*WIDTH  operand B; same packing as in_a
in_op  input  2  relation: 0=EQ, 1=NE, 2=LT (A<B), 3=GE (A>=B)
in_lane_en  input  LANES  per-lane enable
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
out_eq  output  LANES  per-lane A==B, enabled lanes only
out_lt  output  LANES  per-lane A<B, enabled lanes only
out_match  output  LANES  per-lane result of in_op
out_all_match  output  1  all enabled lanes match
cnt_clear  input  1  synchronous clear of match_cnt
match_cnt  output  CNT_W  saturating count of accepted all-match results

Behaviour:
- Reset (async assert, sync to clk on deassert is the integrator's job):
  - out_valid=0, out_eq=0, out_lt=0, out_match=0, out_all_match=0, match_cnt=0.
  - in_ready=1 during and after reset.
- in_ready = !out_valid || out_ready. This is combinational; no other path from out_ready to in_ready.
- Input transfer occurs when in_valid && in_ready. Output transfer occurs when out_valid && out_ready.
- Latency: 1 cycle. Results of an input transfer at edge N appear with out_valid=1 after edge N.
- Throughput: 1 transaction per cycle while out_ready=1.
- Simultaneous output transfer and new input transfer in the same cycle: the output register loads the new result and out_valid stays 1.
- Output transfer without an input transfer: out_valid goes to 0. Data outputs hold their last value and must not be relied upon.
- Backpressure: while out_valid && !out_ready, all out_* hold stable and no input is accepted.
- Per-lane compute, lane i enabled:
  - eq = (a == b).
  - lt = a < b, signed if SIGNED=1, else unsigned.
  - match by in_op: EQ→eq, NE→!eq, LT→lt, GE→!lt.
- Disabled lane: out_eq, out_lt and out_match bits are 0.
- out_all_match = 1 iff in_lane_en != 0 and match==1 for every enabled lane. An all-zero in_lane_en gives 0.
- in_op and in_lane_en are sampled with the operands at input transfer only.
- No X-tolerance is required. Known inputs must produce known outputs, and all registered outputs are known from reset onward.
- Counter:
  - Increments by 1 on each output transfer with out_all_match=1.
  - Saturates at 2^CNT_W-1; it never wraps.
  - cnt_clear=1 forces 0 on the next edge and takes priority over a same-cycle increment.
  - cnt_clear is independent of the handshake.
- Reset mid-stream drops any pending result. No transaction is replayed.

Test Plan:
- Reset asserted mid-transfer with out_valid=1 → out_valid=0, match_cnt=0, in_ready=1 asynchronously; no result emerges after release.
- WIDTH=8, LANES=4, SIGNED=0, in_op=EQ, lane_en=4'hF, a=b=0x01020304, out_ready=1 → next cycle out_eq=4'hF, out_match=4'hF, out_all_match=1, match_cnt=1 after transfer.
- in_op=LT, lane 0 a=0x80 b=0x01: SIGNED=0 → out_lt[0]=0; SIGNED=1 → out_lt[0]=1. in_op=GE gives the complement on out_match[0].
- lane_en=4'b0101 with lanes 1 and 3 mismatching, op EQ → out_eq[1]=out_eq[3]=0, out_all_match=1. lane_en=0 → out_all_match=0.
- Backpressure: out_ready=0 for 5 cycles with in_valid=1 → in_ready=0, outputs stable. Release with out_ready=1 → back-to-back transfers, one per cycle, in order, none lost or duplicated.
- CNT_W=2: 5 all-match transfers → match_cnt=3 (saturated). cnt_clear in the same cycle as an all-match transfer → match_cnt=0.
